// File: rtl/rom_4x4_arbiter.sv
// rom_4x4_arbiter: two-requester round-robin arbiter and read sequencer for
// a shared 4x4 synchronous ROM with a one-cycle registered read.
// Optional statistics (cnt0, cnt1, contend) are enabled by defining the
// macro ROM_ARB_STATS_EN.
module rom_4x4_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  output logic [1:0] gnt,
  output logic [1:0] ack,
  output logic [3:0] rdata,
  output logic       busy,
  output logic       rom_en,
  output logic [1:0] rom_addr,
  input  logic [3:0] rom_data
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1,
  output logic       contend
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic       last_reg, last_next;
  logic [1:0] gnt_reg, gnt_next;
  logic [1:0] ack_reg, ack_next;
  logic [3:0] rdata_reg, rdata_next;
  logic       rom_en_reg, rom_en_next;
  logic [1:0] rom_addr_reg, rom_addr_next;
  logic       win;

  // State and output registers; reset clears everything and favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      gnt_reg      <= 2'b00;
      ack_reg      <= 2'b00;
      rdata_reg    <= 4'h0;
      rom_en_reg   <= 1'b0;
      rom_addr_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      gnt_reg      <= gnt_next;
      ack_reg      <= ack_next;
      rdata_reg    <= rdata_next;
      rom_en_reg   <= rom_en_next;
      rom_addr_reg <= rom_addr_next;
    end
  end

  // Next-state, arbitration and registered-output next values.
  always_comb begin
    state_next    = state_reg;
    last_next     = last_reg;
    gnt_next      = gnt_reg;
    ack_next      = ack_reg;
    rdata_next    = rdata_reg;
    rom_en_next   = rom_en_reg;
    rom_addr_next = rom_addr_reg;
    // On a tie the requester not served last wins; otherwise the lone requester.
    win = (req == 2'b11) ? ~last_reg : req[1];
    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_next      = win ? 2'b10 : 2'b01;
          rom_addr_next = win ? addr1 : addr0;
          rom_en_next   = 1'b1;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        rom_en_next = 1'b0;
        state_next  = WAIT;
      end
      WAIT: begin
        // ROM output is valid now: capture it and acknowledge the winner.
        rdata_next = rom_data;
        ack_next   = gnt_reg;
        last_next  = gnt_reg[1];
        state_next = RESP;
      end
      RESP: begin
        ack_next   = 2'b00;
        gnt_next   = 2'b00;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt      = gnt_reg;
  assign ack      = ack_reg;
  assign rdata    = rdata_reg;
  assign rom_en   = rom_en_reg;
  assign rom_addr = rom_addr_reg;
  // Decoded straight from the state register, so there is no input-to-output path.
  assign busy     = (state_reg != IDLE);

`ifdef ROM_ARB_STATS_EN
  logic [7:0] cnt0_reg, cnt1_reg;
  logic       contend_reg;

  // Saturating per-requester ack counters and a contention pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_reg    <= 8'h00;
      cnt1_reg    <= 8'h00;
      contend_reg <= 1'b0;
    end else begin
      if (ack_reg[0] && cnt0_reg != 8'hFF) cnt0_reg <= cnt0_reg + 8'd1;
      if (ack_reg[1] && cnt1_reg != 8'hFF) cnt1_reg <= cnt1_reg + 8'd1;
      contend_reg <= (state_reg == IDLE) && (req == 2'b11);
    end
  end

  assign cnt0    = cnt0_reg;
  assign cnt1    = cnt1_reg;
  assign contend = contend_reg;
`endif

endmodule

// File: tb/tb_rom_4x4_arbiter.sv
// Directed testbench for rom_4x4_arbiter with a behavioural 4x4 ROM.
// Statistics checks are compiled in when ROM_ARB_STATS_EN is defined.
module tb_rom_4x4_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] addr0, addr1;
  logic [1:0] gnt, ack;
  logic [3:0] rdata;
  logic       busy, rom_en;
  logic [1:0] rom_addr;
  logic [3:0] rom_data = 4'h0;
  int         total = 0;
  int         bad = 0;
  logic [3:0] rom_mem [4];
`ifdef ROM_ARB_STATS_EN
  logic [7:0] cnt0, cnt1;
  logic       contend;
  int         contend_seen;
`endif

  rom_4x4_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
`ifdef ROM_ARB_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1), .contend(contend)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ROM with a registered output.
  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rom_mem[0] = 4'hA; rom_mem[1] = 4'h5; rom_mem[2] = 4'hC; rom_mem[3] = 4'h3;
    req = 2'b00; addr0 = 2'd0; addr1 = 2'd0; rst = 1'b1;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    rst = 1'b0;

    // Simultaneous first requests: requester 0 wins the first tie.
    req = 2'b11; addr0 = 2'd1; addr1 = 2'd3;            // cycle 0
    tick();                                              // cycle 1
    chk("sim_gnt_c1", 32'(gnt), 32'b01);
    chk("sim_rom_en_c1", 32'(rom_en), 1);
    chk("sim_rom_addr_c1", 32'(rom_addr), 1);
    chk("sim_busy_c1", 32'(busy), 1);
`ifdef ROM_ARB_STATS_EN
    chk("sim_contend_c1", 32'(contend), 1);
`endif
    tick();                                              // cycle 2
    chk("sim_rom_en_c2", 32'(rom_en), 0);
    tick();                                              // cycle 3
    chk("sim_ack_c3", 32'(ack), 32'b01);
    chk("sim_rdata_c3", 32'(rdata), 32'h5);
    req = 2'b10;
    tick(); tick();                                      // cycle 5
    chk("sim_gnt_c5", 32'(gnt), 32'b10);
    chk("sim_rom_addr_c5", 32'(rom_addr), 3);
    tick(); tick();                                      // cycle 7
    chk("sim_ack_c7", 32'(ack), 32'b10);
    chk("sim_rdata_c7", 32'(rdata), 32'h3);
    req = 2'b00;
    tick();                                              // IDLE

    // Single read from requester 0 at address 2.
    req = 2'b01; addr0 = 2'd2;                           // cycle 0
    tick();
    chk("single_rom_en_c1", 32'(rom_en), 1);
    tick();
    chk("single_rom_en_c2", 32'(rom_en), 0);
    chk("single_ack_c2", 32'(ack), 0);
    tick();
    chk("single_ack_c3", 32'(ack), 32'b01);
    chk("single_rdata_c3", 32'(rdata), 32'hC);
    req = 2'b00;
    tick();
    chk("single_gnt_c4", 32'(gnt), 0);
    chk("single_ack_c4", 32'(ack), 0);
    chk("single_busy_c4", 32'(busy), 0);

    // Sustained contention after reset: strict alternation starting with 0.
    do_reset();
    req = 2'b11; addr0 = 2'd0; addr1 = 2'd1;             // cycle 0
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("cont_gnt_not11_c%0d", c), 32'(gnt == 2'b11), 0);
      case (c)
        3, 11: begin
          chk($sformatf("cont_ack_c%0d", c), 32'(ack), 32'b01);
          chk($sformatf("cont_rdata_c%0d", c), 32'(rdata), 32'hA);
        end
        7, 15: begin
          chk($sformatf("cont_ack_c%0d", c), 32'(ack), 32'b10);
          chk($sformatf("cont_rdata_c%0d", c), 32'(rdata), 32'h5);
        end
        default: chk($sformatf("cont_ack_c%0d", c), 32'(ack), 0);
      endcase
    end
    req = 2'b00;                                         // IDLE, last = 1

    // Late arrival of requester 1 while requester 0 is in service.
    req = 2'b01; addr0 = 2'd3;                           // cycle 0
    tick();                                              // cycle 1
    req = 2'b11; addr1 = 2'd2;
    tick();                                              // cycle 2
    chk("late_gnt_c2", 32'(gnt), 32'b01);
    tick();                                              // cycle 3
    chk("late_ack_c3", 32'(ack), 32'b01);
    chk("late_rdata_c3", 32'(rdata), 32'h3);
    req = 2'b10;
    tick();                                              // cycle 4
    chk("late_busy_c4", 32'(busy), 0);
    tick();                                              // cycle 5
    chk("late_gnt_c5", 32'(gnt), 32'b10);
    tick(); tick();                                      // cycle 7
    chk("late_ack_c7", 32'(ack), 32'b10);
    chk("late_rdata_c7", 32'(rdata), 32'hC);
    req = 2'b00;
    tick();

    // Reset asserted in WAIT: outputs clear at once, no ack, then a clean retry.
    req = 2'b01; addr0 = 2'd1;                           // cycle 0
    tick(); tick();                                      // cycle 2 (WAIT)
    rst = 1'b1;
    #1;
    chk("rstw_gnt", 32'(gnt), 0);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_rom_addr", 32'(rom_addr), 0);
    chk("rstw_rdata", 32'(rdata), 0);
    tick();                                              // cycle 3
    chk("rstw_ack_c3", 32'(ack), 0);
    rst = 1'b0;
    tick();                                              // cycle 4
    chk("rstw_rom_en_c4", 32'(rom_en), 1);
    tick();
    chk("rstw_ack_c5", 32'(ack), 0);
    tick();                                              // cycle 6
    chk("rstw_ack_c6", 32'(ack), 32'b01);
    chk("rstw_rdata_c6", 32'(rdata), 32'h5);
    req = 2'b00;
    tick();

`ifdef ROM_ARB_STATS_EN
    // 300 back-to-back reads by requester 0 saturate cnt0.
    do_reset();
    contend_seen = 0;
    req = 2'b01; addr0 = 2'd0;
    for (int c = 0; c < 1200; c++) begin
      tick();
      if (contend) contend_seen++;
    end
    req = 2'b00;
    tick(); tick();
    chk("stats_cnt0", 32'(cnt0), 32'hFF);
    chk("stats_cnt1", 32'(cnt1), 0);
    chk("stats_contend_quiet", 32'(contend_seen), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_4x4_arbiter.md
# rom_4x4_arbiter

Two-requester round-robin arbiter and read sequencer for the shared synchronous 4x4 ROM (`ROM_4x4`: registered `data_out`, one-cycle read latency when `en` is high). It accepts read requests from two clients, grants one at a time, drives the ROM's `en`/`address`, captures the ROM word, and returns it with a one-cycle acknowledge. The block sits between the ROM and its consumers, and it is the only driver of the ROM ports.

## Interface
Parameters: none. The ROM geometry is fixed at 4 words x 4 bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 2: per-requester read request, level. `req[i]` is held high until `ack[i]`.
- `addr0` in 2: requester 0 word address. Stable while `req[0]` is high.
- `addr1` in 2: requester 1 word address. Stable while `req[1]` is high.
- `gnt` out 2: one-hot grant. Held from ISSUE through RESP.
- `ack` out 2: one-cycle pulse to the served requester. `rdata` is valid in the same cycle.
- `rdata` out 4: returned ROM word. Shared by both requesters and held until the next capture.
- `busy` out 1: high in every state except IDLE.
- `rom_en` out 1: ROM enable, to ROM `en`.
- `rom_addr` out 2: ROM address, to ROM `address`.
- `rom_data` in 4: from ROM `data_out`.

## Operation
- Registered FSM with four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise select a winner using `last` (the index of the last requester served).
  - Only one requester high: that requester wins.
  - Both high: the requester other than `last` wins.
  - On the clock edge: latch the winner's address, set `gnt`, go to ISSUE.
- ISSUE: `rom_en`=1 and `rom_addr`=latched address, both registered. Go to WAIT.
- WAIT:
  - `rom_en`=0. `rom_addr` holds its value.
  - `rom_data` is valid in this state. On the edge: capture it into `rdata`, set `ack` for the winner, set `last`=winner, go to RESP.
- RESP:
  - `ack` is high for exactly this cycle.
  - On the edge: clear `ack` and `gnt`, return to IDLE.
- `req` is ignored in ISSUE, WAIT and RESP. A request arriving during a transaction waits and is arbitrated in the next IDLE cycle.
- If a requester keeps `req` high in the cycle after its `ack`, that is a new request. It competes with normal round-robin, so it loses to the other requester if both are pending.
- Reset values:
  - `gnt`=0, `ack`=0, `rdata`=0, `busy`=0, `rom_en`=0, `rom_addr`=0.
  - State=IDLE, `last`=1, so requester 0 wins the first tie.
- Reset mid-transaction: all outputs return to their reset values immediately and no `ack` is issued. A requester still holding `req` is re-arbitrated after reset is released.

## Timing
- Cycle n: IDLE with `req` sampled high.
- Cycle n+1: ISSUE, `rom_en` high.
- Cycle n+2: WAIT, `rom_data` valid.
- Cycle n+3: RESP, `ack`/`rdata` valid.
- Request-to-ack latency is 3 cycles. Back-to-back service takes 4 cycles per read.
- Under continuous contention the two requesters alternate. Worst-case wait for a pending requester is 7 cycles.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- `ROM_ARB_STATS_EN`
  - Defined:
    - Adds output ports `cnt0` and `cnt1`, 8 bits each.
    - Each counter increments on its requester's `ack`, saturates at 8'hFF and resets to 0.
    - Adds output `contend` (1 bit), a one-cycle pulse whenever IDLE sees both `req` bits high.
  - Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
Bench ROM contents are {0:4'hA, 1:4'h5, 2:4'hC, 3:4'h3}.
- Single read: `req`=01, `addr0`=2 at cycle 0 -> `rom_en` high in cycle 1 only, `ack`=01 with `rdata`=4'hC in cycle 3, `gnt`=00 in cycle 4.
- Simultaneous first requests: `req`=11, `addr0`=1, `addr1`=3 held -> `ack`=01/`rdata`=4'h5 at cycle 3, then `ack`=10/`rdata`=4'h3 at cycle 7.
- Sustained contention: both `req` held for 16 cycles -> `ack` alternates 01,10,01,10 every 4 cycles, and `gnt` is never 11.
- Late arrival: `req[1]` rises in cycle 1 while requester 0 is in service -> `req[1]` is ignored until IDLE at cycle 4, and `ack`=10 at cycle 7.
- Reset in WAIT: assert `rst` in cycle 2 of a read -> all outputs are 0 in the same cycle and no `ack` appears. After release with `req` still high, a full read completes 3 cycles later.
- With `ROM_ARB_STATS_EN`: 300 reads by requester 0 -> `cnt0`=8'hFF, `cnt1`=0, and `contend` pulses only in the scenarios with simultaneous requests.
